bitstream_accum: RTL and testbench
==================================

BITSTREAM_ACCUM -- requirements
Module: bitstream_accum

Interface
REQ-001 Parameter BITSTREAM, default 64, SHALL be the width of one stochastic bitstream word (one phase-rotated word from the phase stage).
REQ-002 Parameter BEATS_W, default 8, SHALL be the width of the per-frame word counter; max frame length is 2^BEATS_W-1 words.
REQ-003 Derived POP_W = clog2(BITSTREAM+1) and SUM_W = POP_W+BEATS_W SHALL size the popcount and sum (7 and 15 at defaults).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_bits/in_last valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_bits  input  BITSTREAM  rotated bitstream word from the phase stage.
REQ-009 in_last  input  1  final word of the current frame.
REQ-010 out_valid  output  1  frame result held on out_sum/out_beats/out_ovf.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  SUM_W  total count of 1-bits over the frame.
REQ-013 out_beats  output  BEATS_W  number of words in the frame.
REQ-014 out_ovf  output  1  frame was force-terminated at max length.

Function
REQ-015 A word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 Stall condition SHALL be stall = out_valid & ~out_ready; in_ready SHALL equal ~stall (combinational).
REQ-017 While stall=1, the popcount stage, accumulator, beat counter and output registers SHALL all hold.
REQ-018 Stage P SHALL register popcount(in_bits), in_last and a valid flag one cycle after acceptance; P valid SHALL clear when no word is accepted and stall=0.
REQ-019 Stage A SHALL add P popcount into acc (SUM_W, zero-extended) and increment beats on each valid P when stall=0.
REQ-020 When a valid P carries last, or beats reaches 2^BEATS_W-1 with that word, the block SHALL load out_sum=acc+pop, out_beats=beats+1, out_ovf=(~last), set out_valid, and clear acc and beats to 0 in the same cycle.
REQ-021 Latency: last word accepted at edge N SHALL produce out_valid=1 after edge N+2.
REQ-022 out_valid SHALL stay 1 with outputs stable until the edge where out_ready=1; if a new frame end completes on that same edge, out_valid SHALL remain 1 with the new result, else clear.
REQ-023 Frame state SHALL be IDLE (acc=0, beats=0, no P valid), ACCUM (beats>0 or P valid), HOLD (out_valid=1 and stall); IDLE->ACCUM on acceptance, ACCUM->IDLE/HOLD on frame end, HOLD->IDLE/ACCUM on out_ready.
REQ-024 acc SHALL never wrap: SUM_W covers (2^BEATS_W-1)*BITSTREAM.
REQ-025 A word with in_last=1 as the first word SHALL form a one-beat frame.
REQ-026 Results SHALL be independent of rotation: any rotation of the same word SHALL yield the same popcount.
REQ-027 Back-to-back frames SHALL sustain one word per cycle when out_ready=1 continuously.

Reset
REQ-028 rst_n=0 SHALL immediately clear out_valid, out_sum, out_beats, out_ovf, acc, beats and P valid to 0, regardless of clk.
REQ-029 During reset in_ready SHALL read 1 (stall=0); words offered while rst_n=0 SHALL be discarded.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first word after release SHALL start a new frame.

Verification
REQ-031 One word all-ones, in_last=1, out_ready=1 -> out_sum=64, out_beats=1, out_ovf=0, out_valid high exactly 2 edges after acceptance, for one cycle.
REQ-032 Three words 0xFFFF_FFFF_FFFF_FFFF, 0x0000_0000_0000_000F, 0x0 with last on third -> out_sum=68, out_beats=3, out_ovf=0.
REQ-033 out_ready=0 for 5 cycles while result valid, next frame offered -> in_ready=0, outputs stable, no word lost; after out_ready=1 both frames delivered in order.
REQ-034 Assert rst_n=0 after 2 words of a frame, release, send one word 0x0F last -> out_sum=4, out_beats=1.
REQ-035 255 all-ones words with in_last=0 -> out_sum=16320, out_beats=255, out_ovf=1; word 256 starts a new frame.
REQ-036 Same random word rotated by k=0..3, one-beat frames each -> four identical out_sum values.

Source files
------------

// File: rtl/bitstream_accum_if.sv
// Handshake bundle between the phase stage, the frame accumulator and its consumer.
interface bitstream_accum_if #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned BEATS_W   = 8
);
  localparam int unsigned POP_W = $clog2(BITSTREAM + 1);
  localparam int unsigned SUM_W = POP_W + BEATS_W;

  logic                 in_valid;
  logic                 in_ready;
  logic [BITSTREAM-1:0] in_bits;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUM_W-1:0]     out_sum;
  logic [BEATS_W-1:0]   out_beats;
  logic                 out_ovf;

  // Producer of words / consumer of results
  modport master (
    output in_valid, in_bits, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_ovf
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_bits, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_ovf
  );
endinterface

// File: rtl/bitstream_accum.sv
// Frame accumulator: popcounts each stochastic bitstream word, sums the counts
// over a frame (terminated by in_last or by reaching the maximum beat count)
// and presents the total with a valid/ready handshake.
module bitstream_accum #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned BEATS_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bitstream_accum_if.slave bus
);
  localparam int unsigned POP_W = $clog2(BITSTREAM + 1);
  localparam int unsigned SUM_W = POP_W + BEATS_W;
  localparam logic [BEATS_W-1:0] BEATS_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t             state;
  logic               stall;
  logic               accept;
  logic [POP_W-1:0]   pop_in;

  logic               p_valid;
  logic [POP_W-1:0]   p_pop;
  logic               p_last;

  logic [SUM_W-1:0]   acc;
  logic [BEATS_W-1:0] beats;
  logic [SUM_W-1:0]   sum_inc;
  logic [BEATS_W-1:0] beats_inc;
  logic               p_end;

  logic [SUM_W-1:0]   out_sum_q;
  logic [BEATS_W-1:0] out_beats_q;
  logic               out_ovf_q;

  // A held result is out_valid; HOLD is left only through an out_ready edge.
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_ovf   = out_ovf_q;
  assign stall         = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign accept        = bus.in_valid & bus.in_ready;

  // Population count of the incoming word; rotation-invariant by construction.
  always_comb begin
    pop_in = '0;
    for (int unsigned i = 0; i < BITSTREAM; i++) begin
      pop_in = pop_in + POP_W'(bus.in_bits[i]);
    end
  end

  // Next accumulator values and frame-end detection for the word in stage P.
  always_comb begin
    sum_inc   = acc + SUM_W'(p_pop);
    beats_inc = beats + 1'b1;
    p_end     = p_valid & (p_last | (beats_inc == BEATS_MAX));
  end

  // Stage P: register popcount and last flag of the accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_pop   <= '0;
      p_last  <= 1'b0;
    end else if (!stall) begin
      p_valid <= accept;
      if (accept) begin
        p_pop  <= pop_in;
        p_last <= bus.in_last;
      end
    end
  end

  // Stage A + frame state: accumulate, close frames, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      beats       <= '0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      if (p_end) begin
        out_sum_q   <= sum_inc;
        out_beats_q <= beats_inc;
        out_ovf_q   <= ~p_last;
        acc         <= '0;
        beats       <= '0;
        state       <= S_HOLD;
      end else if (p_valid) begin
        acc   <= sum_inc;
        beats <= beats_inc;
        state <= S_ACCUM;
      end else begin
        state <= (accept || beats != '0) ? S_ACCUM : S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bitstream_accum.sv
// Randomized bench for bitstream_accum against a frame-level reference model.
module tb_bitstream_accum;
  localparam int unsigned BS = 64;
  localparam int unsigned BW = 8;
  localparam int unsigned SW = 15;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [BW-1:0] beats;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitstream_accum_if #(.BITSTREAM(BS), .BEATS_W(BW)) bus ();

  bitstream_accum #(.BITSTREAM(BS), .BEATS_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          rand_ready = 1'b0;
  res_t        exp_q[$];
  res_t        got_q[$];
  int unsigned m_sum = 0;
  int unsigned m_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed result handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got_q.push_back({bus.out_sum, bus.out_beats, bus.out_ovf});
  end

  // Reference: frame = words up to last, or 255 words; sum = total ones
  task automatic model_word(input logic [63:0] w, input bit last);
    m_sum += $countones(w);
    m_n++;
    if (last || m_n == 255) begin
      exp_q.push_back({SW'(m_sum), BW'(m_n), 1'(!last)});
      m_sum = 0;
      m_n   = 0;
    end
  endtask

  task automatic model_clear();
    m_sum = 0;
    m_n   = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] w, input int k);
    return (k == 0) ? w : ((w << k) | (w >> (64 - k)));
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Offer one word until accepted; returns 1 time unit after the accepting edge
  task automatic send_word(input logic [63:0] w, input bit last);
    bit rdy;
    bit done;
    done = 1'b0;
    model_word(w, last);
    bus.in_valid = 1'b1;
    bus.in_bits  = w;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word not accepted within 200 cycles, in_ready=%0b", bus.in_ready);
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bits = '1;
    bus.in_last = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_beats !== '0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b sum=%0d beats=%0d ovf=%0b, want all 0",
               bus.out_valid, bus.out_sum, bus.out_beats, bus.out_ovf);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got %0d results out_valid=%0b, want 0 results", got_q.size(), bus.out_valid);
    end
    model_clear();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send_word('1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_hold: out_valid got %0b want 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_beats !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_clear: got v=%0b sum=%0d beats=%0d rdy=%0b, want 0 0 0 1",
               bus.out_valid, bus.out_sum, bus.out_beats, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_bits = 64'h00FF;
    bus.in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_discard: got %0d results out_valid=%0b, want 0", got_q.size(), bus.out_valid);
    end
    model_clear();
  endtask

  task automatic test_single_beat();
    bus.out_ready = 1'b1;
    send_word('1, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: out_valid got %0b want 0 one edge after accept", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 15'd64 || bus.out_beats !== 8'd1 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got v=%0b sum=%0d beats=%0d ovf=%0b, want 1 64 1 0",
               bus.out_valid, bus.out_sum, bus.out_beats, bus.out_ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: out_valid got %0b want 0", bus.out_valid);
    end
    model_clear();
  endtask

  task automatic test_three_words();
    bit ok;
    bus.out_ready = 1'b1;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_word(64'h0000_0000_0000_000F, 1'b0);
    send_word(64'h0, 1'b1);
    wait_results(1, ok);
    checks++;
    if (!ok || got_q[0] !== res_t'({15'd68, 8'd3, 1'b0})) begin
      errors++;
      $display("FAIL three_words: got %0d results first=%h, want sum=68 beats=3 ovf=0",
               got_q.size(), ok ? got_q[0] : res_t'('0));
    end
    model_clear();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [63:0] b0;
    bus.out_ready = 1'b0;
    send_word(rand64(), 1'b0);
    send_word(rand64(), 1'b1);
    @(posedge clk);
    #1;
    b0 = rand64();
    bus.in_valid = 1'b1;
    bus.in_bits = b0;
    bus.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          {bus.out_sum, bus.out_beats, bus.out_ovf} !== exp_q[0]) begin
        errors++;
        $display("FAIL hold_cycle%0d: got rdy=%0b v=%0b res=%h, want rdy=0 v=1 res=%h",
                 i, bus.in_ready, bus.out_valid, {bus.out_sum, bus.out_beats, bus.out_ovf}, exp_q[0]);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_word(b0, 1'b0);
    send_word(rand64(), 1'b1);
    wait_results(exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL hold_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    model_clear();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bus.out_ready = 1'b1;
    send_word(rand64(), 1'b0);
    send_word(rand64(), 1'b0);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    send_word(64'h0F, 1'b1);
    wait_results(1, ok);
    checks++;
    if (!ok || got_q[0] !== res_t'({15'd4, 8'd1, 1'b0}) || exp_q[0] !== got_q[0]) begin
      errors++;
      $display("FAIL reset_midframe: got %0d results first=%h, want sum=4 beats=1 ovf=0",
               got_q.size(), ok ? got_q[0] : res_t'('0));
    end
    model_clear();
  endtask

  task automatic test_max_length();
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 255; i++) send_word('1, 1'b0);
    send_word(rand64(), 1'b1);
    wait_results(2, ok);
    checks++;
    if (!ok || got_q[0] !== res_t'({15'd16320, 8'd255, 1'b1})) begin
      errors++;
      $display("FAIL max_len: got %0d results first=%h, want sum=16320 beats=255 ovf=1",
               got_q.size(), ok ? got_q[0] : res_t'('0));
    end
    checks++;
    if (!ok || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL max_next_frame: got %h want %h", ok ? got_q[1] : res_t'('0), exp_q[1]);
    end
    model_clear();
  endtask

  task automatic test_rotation();
    bit ok;
    logic [63:0] w;
    w = rand64();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_word(rotl(w, k), 1'b1);
    wait_results(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rot_count: got %0d results want 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || got_q[k].sum !== SW'($countones(w))) begin
        errors++;
        $display("FAIL rot_k%0d: got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
    model_clear();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int unsigned t0;
    int unsigned nwords;
    bus.out_ready = 1'b1;
    nwords = 0;
    t0 = cyc;
    for (int f = 0; f < 6; f++) begin
      int unsigned len;
      len = $urandom_range(1, 6);
      for (int unsigned j = 0; j < len; j++) begin
        send_word(rand64(), j == len - 1);
        nwords++;
      end
    end
    checks++;
    if (cyc - t0 !== nwords) begin
      errors++;
      $display("FAIL b2b_rate: got %0d cycles for %0d words, want %0d", cyc - t0, nwords, nwords);
    end
    wait_results(exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    model_clear();
  endtask

  task automatic test_random_backpressure();
    bit ok;
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int unsigned len;
      len = $urandom_range(1, 8);
      for (int unsigned j = 0; j < len; j++) send_word(rand64(), j == len - 1);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_results(exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rbp_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rbp_frame%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    model_clear();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_beat();
    test_three_words();
    test_backpressure();
    test_async_reset();
    test_reset_midframe();
    test_max_length();
    test_rotation();
    test_back_to_back();
    test_random_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
